dmem_arbiter: RTL and testbench

- Shares the single-port data memory (DataMemo) between two requesters: the pipeline MEM stage and an external loader/debug port (program/data preload, inspection).
- The pipeline has priority. A starvation counter guarantees the loader a bounded forced window; during that window the pipeline is stalled.
- Sits between the MEM stage, the loader, and DataMemo. pipe_stall feeds the stall/disable logic next to the Hazard_Unit Stall output.

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMemo between the pipeline MEM stage
// and an external loader/debug port. The pipeline has priority. A starvation
// counter gives the loader a bounded forced window, during which a competing
// pipeline access is stalled.
// Ports:
//   clk, reset (async, active-low)
//   pipe_rd/pipe_wr/pipe_addr/pipe_wdata  MEM-stage request
//   pipe_rdata (comb), pipe_stall (comb)  MEM-stage response / hold
//   ld_req/ld_we/ld_addr/ld_wdata         loader request
//   ld_gnt (comb), ld_rvalid/ld_rdata (registered, 1-cycle read latency)
//   MemRd/MemWr_final/Address/Data_in     to DataMemo
//   Data_out                              from DataMemo (combinational read)
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned FORCE_LEN = 2,
  parameter int unsigned DW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_rd,
  input  logic          pipe_wr,
  input  logic [DW-1:0] pipe_addr,
  input  logic [DW-1:0] pipe_wdata,
  output logic [DW-1:0] pipe_rdata,
  output logic          pipe_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [DW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          MemRd,
  output logic          MemWr_final,
  output logic [DW-1:0] Address,
  output logic [DW-1:0] Data_in,
  input  logic [DW-1:0] Data_out
);

  localparam int unsigned WCW = $clog2(MAX_WAIT) + 1;
  localparam int unsigned FCW = $clog2(FORCE_LEN) + 1;

  typedef enum logic {ST_PIPE, ST_FORCE} state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [FCW-1:0] force_cnt;
  logic           pipe_act;

  assign pipe_act = pipe_rd | pipe_wr;

  // Grant, stall and memory mux; everything forced to zero while in reset.
  always_comb begin
    ld_gnt      = 1'b0;
    pipe_stall  = 1'b0;
    MemRd       = 1'b0;
    MemWr_final = 1'b0;
    Address     = '0;
    Data_in     = '0;
    pipe_rdata  = '0;
    if (reset) begin
      if (state == ST_FORCE) begin
        ld_gnt     = ld_req;
        pipe_stall = ld_req & pipe_act;
      end else begin
        ld_gnt     = ld_req & ~pipe_act;
      end
      if (ld_gnt) begin
        MemRd       = ~ld_we;
        MemWr_final = ld_we;
        Address     = ld_addr;
        Data_in     = ld_wdata;
      end else begin
        MemRd       = pipe_rd;
        MemWr_final = pipe_wr;
        Address     = pipe_addr;
        Data_in     = pipe_wdata;
        pipe_rdata  = Data_out;
      end
    end
  end

  // Arbitration state, starvation/window counters and loader read return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_PIPE;
      wait_cnt  <= '0;
      force_cnt <= '0;
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
    end else begin
      if (ld_gnt && !ld_we) begin
        ld_rvalid <= 1'b1;
        ld_rdata  <= Data_out;
      end else begin
        ld_rvalid <= 1'b0;
      end

      case (state)
        ST_PIPE: begin
          if (ld_req && pipe_act) begin
            if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
              state     <= ST_FORCE;
              wait_cnt  <= '0;
              force_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + WCW'(1);
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_FORCE: begin
          // Window ends early when the loader lets go, or after FORCE_LEN cycles.
          if (!ld_req || force_cnt == FCW'(FORCE_LEN - 1)) begin
            state <= ST_PIPE;
          end else begin
            force_cnt <= force_cnt + FCW'(1);
          end
        end
        default: state <= ST_PIPE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: the bench also plays DataMemo and keeps a
// reference model (streak counts + shadow memory) of the arbitration rules.
module tb_dmem_arbiter;

  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned FORCE_LEN = 2;
  localparam int unsigned DW        = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_rd, pipe_wr;
  logic [DW-1:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic          pipe_stall;
  logic          ld_req, ld_we;
  logic [DW-1:0] ld_addr, ld_wdata, ld_rdata;
  logic          ld_gnt, ld_rvalid;
  logic          MemRd, MemWr_final;
  logic [DW-1:0] Address, Data_in, Data_out;

  int checks = 0;
  int errors = 0;

  // DataMemo stand-in: combinational read, write on the rising edge.
  logic [DW-1:0] mem [0:255];
  assign Data_out = mem[Address[7:0]];
  always @(posedge clk) if (MemWr_final) mem[Address[7:0]] <= Data_in;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .FORCE_LEN(FORCE_LEN), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .MemRd(MemRd), .MemWr_final(MemWr_final), .Address(Address),
    .Data_in(Data_in), .Data_out(Data_out)
  );

  // Reference model: how long the loader has been denied / has held a window.
  bit            m_forcing;
  int            m_denied;
  int            m_forced;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [0:255];

  bit obs_gnt, obs_stall, obs_rvalid;
  logic [DW-1:0] obs_rdata;

  task automatic model_reset();
    m_forcing = 0; m_denied = 0; m_forced = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit prd, input bit pwr, input logic [DW-1:0] pa,
                      input logic [DW-1:0] pd, input bit lreq, input bit lwe,
                      input logic [DW-1:0] la, input logic [DW-1:0] ld);
    bit pact, egnt, estall;
    logic [3+4*DW-1:0] exp_c, got_c;
    pipe_rd = prd; pipe_wr = pwr; pipe_addr = pa; pipe_wdata = pd;
    ld_req = lreq; ld_we = lwe; ld_addr = la; ld_wdata = ld;
    #1;
    pact   = prd | pwr;
    egnt   = m_forcing ? lreq : (lreq && !pact);
    estall = m_forcing && lreq && pact;
    if (egnt) exp_c = {egnt, estall, !lwe, lwe, la, ld, DW'(0)};
    else      exp_c = {egnt, estall, prd, pwr, pa, pd, ref_mem[pa[7:0]]};
    got_c = {ld_gnt, pipe_stall, MemRd, MemWr_final, Address, Data_in, pipe_rdata};
    obs_gnt = ld_gnt; obs_stall = pipe_stall;
    checks++;
    if (got_c !== exp_c) begin
      errors++;
      $display("FAIL comb gnt/stall/rd/wr/addr/din/prdata got %h expected %h", got_c, exp_c);
    end
    @(posedge clk);
    if (egnt && !lwe) begin m_rvalid = 1; m_rdata = ref_mem[la[7:0]]; end
    else m_rvalid = 0;
    if (egnt && lwe) ref_mem[la[7:0]] = ld;
    else if (!egnt && pwr) ref_mem[pa[7:0]] = pd;
    if (!m_forcing) begin
      if (lreq && pact) begin
        m_denied++;
        if (m_denied == MAX_WAIT) begin m_forcing = 1; m_denied = 0; m_forced = 0; end
      end else m_denied = 0;
    end else begin
      if (!lreq) m_forcing = 0;
      else begin
        m_forced++;
        if (m_forced == FORCE_LEN) m_forcing = 0;
      end
    end
    #1;
    obs_rvalid = ld_rvalid; obs_rdata = ld_rdata;
    checks++;
    if ({ld_rvalid, ld_rdata} !== {m_rvalid, m_rdata}) begin
      errors++;
      $display("FAIL rvalid/rdata got %b/%h expected %b/%h", ld_rvalid, ld_rdata, m_rvalid, m_rdata);
    end
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b0; pipe_rd = 0; pipe_wr = 1; pipe_addr = 32'd3; pipe_wdata = 32'hDEAD;
    ld_req = 1; ld_we = 1; ld_addr = 32'd4; ld_wdata = 32'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ld_gnt, MemWr_final, pipe_stall, ld_rvalid, ld_rdata} !== {4'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset gnt/wr/stall/rvalid/rdata got %b%b%b%b/%h expected 0000/0",
               ld_gnt, MemWr_final, pipe_stall, ld_rvalid, ld_rdata);
    end
    checks++;
    if ({MemRd, Address, Data_in, pipe_rdata} !== {1'b0, 96'h0}) begin
      errors++;
      $display("FAIL reset_mux got rd=%b addr=%h din=%h prdata=%h expected zeros",
               MemRd, Address, Data_in, pipe_rdata);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    idle();
  endtask

  task automatic test_idle_loader();
    step(0, 0, '0, '0, 1, 1, 32'd10, 32'hAAAA5555);
    checks++;
    if (obs_gnt !== 1'b1) begin errors++; $display("FAIL idle_wr_gnt got %b expected 1", obs_gnt); end
    checks++;
    if (mem[10] !== 32'hAAAA5555) begin errors++; $display("FAIL idle_wr_mem got %h expected aaaa5555", mem[10]); end
    step(0, 0, '0, '0, 1, 0, 32'd10, '0);
    checks++;
    if ({obs_rvalid, obs_rdata} !== {1'b1, 32'hAAAA5555}) begin
      errors++; $display("FAIL idle_rd got %b/%h expected 1/aaaa5555", obs_rvalid, obs_rdata);
    end
    idle();
    checks++;
    if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid_drop got %b expected 0", obs_rvalid); end
  endtask

  task automatic test_starvation();
    logic [11:0] gv, sv, exp_v;
    exp_v = 12'hC30;
    step(0, 0, '0, '0, 1, 1, 32'd20, 32'h12345678);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 32'd5, '0, 1, 0, 32'd20, '0);
      gv[i] = obs_gnt; sv[i] = obs_stall;
      if (i == 4) begin
        checks++;
        if ({obs_rvalid, obs_rdata} !== {1'b1, 32'h12345678}) begin
          errors++; $display("FAIL starve_rdata got %b/%h expected 1/12345678", obs_rvalid, obs_rdata);
        end
      end
    end
    checks++;
    if (gv !== exp_v) begin errors++; $display("FAIL starve_gnt_pattern got %h expected %h", gv, exp_v); end
    checks++;
    if (sv !== exp_v) begin errors++; $display("FAIL starve_stall_pattern got %h expected %h", sv, exp_v); end
    idle();
  endtask

  task automatic test_counter_clear();
    logic [8:0] gv, exp_v;
    exp_v = 9'h100;
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 32'd6, '0, (i != 3), 0, 32'd20, '0);
      gv[i] = obs_gnt;
    end
    checks++;
    if (gv !== exp_v) begin errors++; $display("FAIL clear_gnt_pattern got %h expected %h", gv, exp_v); end
    idle();
  endtask

  task automatic test_force_collision();
    for (int i = 0; i < MAX_WAIT; i++) step(0, 1, 32'd10, 32'hFFFFFFFF, 1, 1, 32'd10, 32'h11111111);
    step(0, 1, 32'd10, 32'hFFFFFFFF, 1, 1, 32'd10, 32'h11111111);
    checks++;
    if ({obs_stall, mem[10]} !== {1'b1, 32'h11111111}) begin
      errors++; $display("FAIL collide got stall=%b mem=%h expected 1/11111111", obs_stall, mem[10]);
    end
    step(0, 1, 32'd10, 32'hFFFFFFFF, 0, 0, '0, '0);
    checks++;
    if ({obs_stall, mem[10]} !== {1'b0, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL early_exit got stall=%b mem=%h expected 0/ffffffff", obs_stall, mem[10]);
    end
    idle();
  endtask

  task automatic test_reset_mid_force();
    logic [4:0] gv;
    for (int i = 0; i < MAX_WAIT; i++) step(1, 0, 32'd7, '0, 1, 0, 32'd20, '0);
    pipe_rd = 1; ld_req = 1; ld_we = 0; ld_addr = 32'd20;
    #1;
    checks++;
    if ({ld_gnt, pipe_stall} !== 2'b11) begin
      errors++; $display("FAIL force_entry got gnt/stall %b%b expected 11", ld_gnt, pipe_stall);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({ld_gnt, pipe_stall, ld_rvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_abort got gnt/stall/rvalid %b%b%b expected 000", ld_gnt, pipe_stall, ld_rvalid);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 32'd7, '0, 1, 0, 32'd20, '0);
      gv[i] = obs_gnt;
    end
    checks++;
    if (gv !== 5'b10000) begin errors++; $display("FAIL post_reset_gnt got %b expected 10000", gv); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit prd, pwr, lreq, lwe;
      prd  = ($urandom_range(0, 9) < 4);
      pwr  = !prd && ($urandom_range(0, 9) < 4);
      lreq = ($urandom_range(0, 9) < 7);
      lwe  = $urandom_range(0, 1) == 1;
      step(prd, pwr, DW'($urandom_range(0, 15)), $urandom, lreq, lwe,
           DW'($urandom_range(0, 15)), $urandom);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    model_reset();
    #1;
    test_reset();
    test_idle_loader();
    test_starvation();
    test_counter_clear();
    test_force_collision();
    test_reset_mid_force();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
